// File: rtl/bouncebox_pkg.sv
// bouncebox_pkg: shared coordinate width, pixel type and fixed colours for
// the bouncing-box pixel source.
package bouncebox_pkg;

    localparam int COORD_W = 10;

    typedef logic [23:0] rgb_t;

    localparam rgb_t WHITE_RGB = 24'hFFFFFF;

    // True when coordinate c lies in the half-open span [base, base+size).
    function automatic logic in_span(input logic [COORD_W-1:0] c,
                                     input logic [COORD_W-1:0] base,
                                     input int unsigned        size);
        logic [COORD_W:0] c_w;
        logic [COORD_W:0] lo_w;
        logic [COORD_W:0] hi_w;
        c_w  = {1'b0, c};
        lo_w = {1'b0, base};
        hi_w = lo_w + (COORD_W + 1)'(size);
        return (c_w >= lo_w) && (c_w < hi_w);
    endfunction

endpackage

// File: rtl/bouncebox_axis.sv
// bouncebox_axis: position and direction of the box along one screen axis.
// Steps once per frame strobe, reflecting off 0 and LIMIT without wrapping.
// o_pos_next is the position that will be held after this edge, so the top
// level can colour the next pixel without an extra cycle of latency.
module bouncebox_axis
    import bouncebox_pkg::*;
#(
    parameter int LIMIT    = 640,
    parameter int BOX_SIZE = 32,
    parameter int SPEED    = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_step,
    output logic [COORD_W-1:0] o_pos_next
);

    localparam logic [COORD_W+1:0] REACH = (COORD_W + 2)'(BOX_SIZE + SPEED);
    localparam logic [COORD_W+1:0] LIM_W = (COORD_W + 2)'(LIMIT);
    localparam logic [COORD_W-1:0] HOME  = COORD_W'(LIMIT - BOX_SIZE);
    localparam logic [COORD_W-1:0] STEP  = COORD_W'(SPEED);

    logic [COORD_W-1:0] pos_q, pos_d;
    logic               dir_q, dir_d;

    // Next position/direction: clamp to the far edge or to zero on a bounce.
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (i_step) begin
            if (!dir_q && (({2'b00, pos_q} + REACH) > LIM_W)) begin
                dir_d = 1'b1;
                pos_d = HOME;
            end else if (dir_q && (pos_q < STEP)) begin
                dir_d = 1'b0;
                pos_d = '0;
            end else if (dir_q) begin
                pos_d = pos_q - STEP;
            end else begin
                pos_d = pos_q + STEP;
            end
        end
    end

    // Position/direction registers with synchronous reset to the origin.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pos_q <= '0;
            dir_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign o_pos_next = pos_d;

endmodule

// File: rtl/bouncebox_src.sv
// bouncebox_src: pixel source drawing a solid box bouncing on a flat
// background, paced by the encoder's read/new-line/new-frame strobes.
// Optional build macro: BOUNCEBOX_BORDER_EN draws a one-pixel white frame
// around the visible area (border wins over the box).
module bouncebox_src
    import bouncebox_pkg::*;
#(
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480,
    parameter int          BOX_SIZE = 32,
    parameter int          SPEED    = 2,
    parameter logic [23:0] BG_RGB   = 24'h000040,
    parameter logic [23:0] BOX_RGB  = 24'hFFC000
) (
    input  logic        i_pixclk,
    input  logic        i_reset,
    input  logic        i_rd,
    input  logic        i_newline,
    input  logic        i_newframe,
    output logic [23:0] o_pixel
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_ACTIVE - 1);

`ifdef BOUNCEBOX_BORDER_EN
    localparam rgb_t RESET_RGB = WHITE_RGB;
`else
    localparam rgb_t RESET_RGB = BOX_RGB;
`endif

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [COORD_W-1:0] bx_next, by_next;
    rgb_t               pixel_q, pixel_d;

    bouncebox_axis #(
        .LIMIT    (H_ACTIVE),
        .BOX_SIZE (BOX_SIZE),
        .SPEED    (SPEED)
    ) u_axis_x (
        .i_clk      (i_pixclk),
        .i_reset    (i_reset),
        .i_step     (i_newframe),
        .o_pos_next (bx_next)
    );

    bouncebox_axis #(
        .LIMIT    (V_ACTIVE),
        .BOX_SIZE (BOX_SIZE),
        .SPEED    (SPEED)
    ) u_axis_y (
        .i_clk      (i_pixclk),
        .i_reset    (i_reset),
        .i_step     (i_newframe),
        .o_pos_next (by_next)
    );

    // Raster advance by strobe priority, then colour of the next raster pixel.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (i_newframe) begin
            x_d = '0;
            y_d = '0;
        end else if (i_newline) begin
            x_d = '0;
            if (y_q != Y_MAX) y_d = y_q + COORD_W'(1);
        end else if (i_rd) begin
            if (x_q != X_MAX) x_d = x_q + COORD_W'(1);
        end

        if (in_span(x_d, bx_next, BOX_SIZE) && in_span(y_d, by_next, BOX_SIZE))
            pixel_d = BOX_RGB;
        else
            pixel_d = BG_RGB;
`ifdef BOUNCEBOX_BORDER_EN
        if ((x_d == '0) || (x_d == X_MAX) || (y_d == '0) || (y_d == Y_MAX))
            pixel_d = WHITE_RGB;
`endif
    end

    // Raster counters and output pixel register; reset overrides all strobes.
    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            x_q     <= '0;
            y_q     <= '0;
            pixel_q <= RESET_RGB;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            pixel_q <= pixel_d;
        end
    end

    assign o_pixel = pixel_q;

endmodule

// File: tb/tb_bouncebox_src.sv
// tb_bouncebox_src: directed checks of raster stepping, box hit test,
// bouncing motion and reset for bouncebox_src (default parameters).
module tb_bouncebox_src;

    localparam logic [23:0] BG    = 24'h000040;
    localparam logic [23:0] BOX   = 24'hFFC000;
    localparam logic [23:0] WHITE = 24'hFFFFFF;

`ifdef BOUNCEBOX_BORDER_EN
    localparam logic [23:0] EDGE_BOX = WHITE;
    localparam logic [23:0] EDGE_BG  = WHITE;
`else
    localparam logic [23:0] EDGE_BOX = BOX;
    localparam logic [23:0] EDGE_BG  = BG;
`endif

    logic        i_pixclk = 1'b0;
    logic        i_reset  = 1'b1;
    logic        i_rd     = 1'b0;
    logic        i_newline  = 1'b0;
    logic        i_newframe = 1'b0;
    logic [23:0] o_pixel;

    int n_checks = 0;
    int n_fail   = 0;

    bouncebox_src dut (
        .i_pixclk   (i_pixclk),
        .i_reset    (i_reset),
        .i_rd       (i_rd),
        .i_newline  (i_newline),
        .i_newframe (i_newframe),
        .o_pixel    (o_pixel)
    );

    always #20 i_pixclk = ~i_pixclk;

    // One clock with the given strobes; inputs change 1 time unit after the edge.
    task automatic cyc(input logic rd, input logic nl, input logic nf);
        i_rd       = rd;
        i_newline  = nl;
        i_newframe = nf;
        @(posedge i_pixclk);
        #1;
        i_rd       = 1'b0;
        i_newline  = 1'b0;
        i_newframe = 1'b0;
    endtask

    task automatic reads(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic newlines(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0);
    endtask

    task automatic newframes(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk(input string tag, input logic [23:0] expected);
        n_checks++;
        assert (o_pixel === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o_pixel, expected);
        end
    endtask

    initial begin
        // reset held
        i_reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("reset_value", EDGE_BOX);
        i_reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        chk("after_reset_0_0", EDGE_BOX);

        // reads along line 0 with box at (0,0)
        reads(1);  chk("x1_y0", EDGE_BOX);
        reads(1);  chk("x2_y0", EDGE_BOX);
        reads(29); chk("x31_y0", EDGE_BOX);
        reads(1);  chk("x32_y0", EDGE_BG);
        reads(668); chk("x_sat_y0", EDGE_BG);

        // first frame: box at (2,2)
        newframes(1); chk("f1_0_0", EDGE_BG);
        newlines(1);  chk("f1_0_1", EDGE_BG);
        reads(1);     chk("f1_1_1", BG);
        newlines(1);
        reads(1);     chk("f1_1_2", BG);
        reads(1);     chk("f1_2_2", BOX);

        // newline and newframe together: one frame step, raster at (0,0)
        cyc(1'b1, 1'b1, 1'b1); chk("f2_0_0", EDGE_BG);
        newlines(4);
        reads(3);     chk("f2_3_4", BG);
        reads(1);     chk("f2_4_4", BOX);

        // frames 3..305: x bounces at 608, y on its way down at 288
        newframes(303); chk("f305_0_0", EDGE_BG);
        newlines(288);
        reads(607);   chk("f305_607_288", BG);
        reads(1);     chk("f305_608_288", BOX);
        reads(93);    chk("f305_xsat_288", EDGE_BOX);
        newlines(1);  chk("f305_0_289", EDGE_BG);

        // frame 306: box at (606,286)
        newframes(1); chk("f306_0_0", EDGE_BG);
        newlines(286);
        reads(605);   chk("f306_605_286", BG);
        reads(1);     chk("f306_606_286", BOX);
        reads(31);    chk("f306_637_286", BOX);
        reads(1);     chk("f306_638_286", BG);

        // reset with strobes active returns to the origin state
        i_reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        chk("midline_reset", EDGE_BOX);
        i_reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        chk("post_reset_0_0", EDGE_BOX);
        newframes(1); chk("post_reset_f1", EDGE_BG);
        newlines(2);
        reads(2);     chk("post_reset_f1_2_2", BOX);

`ifdef BOUNCEBOX_BORDER_EN
        // border: right edge on line 5, whole of last line
        newframes(1);
        newlines(5);
        reads(638);   chk("border_638_5", BG);
        reads(62);    chk("border_639_5", WHITE);
        newlines(500); chk("border_0_479", WHITE);
        reads(100);   chk("border_100_479", WHITE);
        reads(300);   chk("border_400_479", WHITE);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bouncebox_src.md
# bouncebox_src

Upstream pixel source for the HDMI encoder stage. It replaces the static test pattern generator and renders a solid box that bounces off the screen edges on a flat background. It is paced entirely by the encoder's read, new-line and new-frame strobes, and presents one 24-bit RGB pixel per read on the pixel clock.

## Interface

Parameters:
- H_ACTIVE, 640: visible pixels per line.
- V_ACTIVE, 480: visible lines per frame.
- BOX_SIZE, 32: box edge length in pixels; must satisfy BOX_SIZE + SPEED <= min(H_ACTIVE, V_ACTIVE).
- SPEED, 2: pixels moved per frame per axis, range 1..15.
- BG_RGB, 24'h000040: background colour.
- BOX_RGB, 24'hFFC000: box colour.

Ports:
- i_pixclk, in, 1: pixel clock (25 MHz); sole clock.
- i_reset, in, 1: reset; **synchronous, active-high**.
- i_rd, in, 1: encoder consumes the current o_pixel this cycle.
- i_newline, in, 1: one-cycle strobe, end of current line.
- i_newframe, in, 1: one-cycle strobe, start of new frame.
- o_pixel, out, 24: {R[23:16], G[15:8], B[7:0]}, registered.

## Operation

- Raster counters: x and y, each 10 bits unsigned.
- o_pixel always holds the colour of raster position (x, y), i.e. the pixel the next i_rd consumes.
- A pixel is inside the box when bx <= x < bx+BOX_SIZE and by <= y < by+BOX_SIZE; otherwise it is background.
- Strobe priority in a single cycle: i_newframe > i_newline > i_rd.
  - i_newframe: x←0, y←0; box position updated (see motion below).
  - i_newline: x←0; y←y+1, saturating at V_ACTIVE−1.
  - i_rd: x←x+1, saturating at H_ACTIVE−1 (excess reads repeat the last pixel).
- Motion, per axis, on each i_newframe:
  - Direction bit d: 0 = increasing, 1 = decreasing.
  - If d=0 and pos+BOX_SIZE+SPEED > limit: set d←1 and pos←limit−BOX_SIZE.
  - Else if d=1 and pos < SPEED: set d←0 and pos←0.
  - Otherwise pos ± SPEED.
  - Position is clamped, never wraps.
- Reset values: x=0, y=0, bx=0, by=0, both d=0. o_pixel=BOX_RGB, because (0,0) lies inside the box at reset.
- Reset mid-line overrides all strobes; output is correct for (0,0) the cycle after reset deasserts.

## Timing

- Single clock domain; all state updates on the rising edge of i_pixclk.
- o_pixel is updated in the same edge as the counter update. It reflects the new (x, y, bx, by) one cycle after the strobe.
- Next-pixel colour is computed combinationally from the next-state counters, then registered; no extra pipeline latency.
- A frame's box position is stable from i_newframe until the next i_newframe, so there is no tearing.
- No backpressure: i_rd is never refused.

## Configuration

- BOUNCEBOX_BORDER_EN defined:
  - Pixels with x==0, x==H_ACTIVE−1, y==0 or y==V_ACTIVE−1 output 24'hFFFFFF.
  - The border has priority over the box.
  - Reset value of o_pixel becomes 24'hFFFFFF.
- Undefined: no border logic; the edges show box or background as normal.

## Structure

- Package bouncebox_pkg:
  - COORD_W=10
  - rgb_t (24-bit packed)
  - WHITE_RGB constant
- Sub-module bouncebox_axis:
  - One instance per axis, parameterised by limit, BOX_SIZE and SPEED.
  - Holds pos and d; advances on a frame strobe; synchronous reset to pos=0, d=0.
- Top level holds the raster counters, the inside-box compare and the output register.

## Test plan

- Reset then 3 reads, defaults, border off -> o_pixel BOX_RGB for x=0..2; x=32 after 32 reads -> BG_RGB.
- 700 reads without newline -> x saturates at 639; o_pixel stable at the x=639 colour.
- newframe ×1 -> bx=by=2; pixel (1,1) BG_RGB, (2,2) BOX_RGB.
- 305 newframes (bx reaches 608 at frame 304, then 608+32+2>640) -> d_x=1, bx=608; next frame bx=606.
- Strobes newline and newframe asserted in the same cycle -> y=0, position advanced once, not twice.
- BOUNCEBOX_BORDER_EN defined; after reset, read to x=639 on line 5 -> 24'hFFFFFF at x=639; at line 479 all pixels white.
